// File: rtl/lsu_wide.sv
// Load/store unit bridging one 64-bit request per instruction onto a pipelined
// Wishbone B4 master of DW bits, with byte-lane steering and multi-beat splits.
module lsu_wide #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [63:0]     addr_i,
  input  logic [63:0]     dat_i,
  input  logic            we_i,
  input  logic            mem_i,
  input  logic            nomem_i,
  input  logic [2:0]      xrs_rwe_i,
  input  logic [4:0]      xrs_rd_i,
  output logic            busy_o,
  output logic [2:0]      rwe_o,
  output logic [63:0]     dat_o,
  output logic [4:0]      rd_o,
  output logic            misalign_o,
  output logic [AW-1:0]   wbmadr_o,
  output logic [DW-1:0]   wbmdat_o,
  output logic [DW/8-1:0] wbmsel_o,
  output logic            wbmwe_o,
  output logic            wbmstb_o,
  input  logic            wbmack_i,
  input  logic            wbmstall_i,
  input  logic [DW-1:0]   wbmdat_i
);
  localparam int unsigned L    = DW / 8;
  localparam int unsigned LSH  = $clog2(L);
  localparam int unsigned MAXB = 64 / DW;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;

  logic [63:0] addr_q, dat_q, result_q, result_n;
  logic        we_q;
  logic [2:0]  code_q;
  logic [4:0]  rd_q;
  logic [2:0]  issue_cnt, ack_cnt, beats, lane, lane_mask;
  logic [3:0]  n_q, n_in;
  logic [7:0]  mask8, sel8;
  logic        misaligned, stb, accept, ack_en, acks_done;

  function automatic logic [3:0] size_bytes(input logic [2:0] code);
    case (code[1:0])
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      2'b11:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [2:0] code, input logic [63:0] r);
    case (code)
      3'b001:  return {{56{r[7]}}, r[7:0]};
      3'b010:  return {{48{r[15]}}, r[15:0]};
      3'b011:  return {{32{r[31]}}, r[31:0]};
      3'b101:  return {56'd0, r[7:0]};
      3'b110:  return {48'd0, r[15:0]};
      3'b111:  return {32'd0, r[31:0]};
      default: return r;
    endcase
  endfunction

  assign n_in       = size_bytes(xrs_rwe_i);
  assign misaligned = |(addr_i[3:0] & (n_in - 4'd1));
  assign n_q        = size_bytes(code_q);
  assign beats      = (n_q >= 4'(L)) ? 3'(n_q >> LSH) : 3'd1;
  assign lane       = 3'(addr_q[LSH-1:0]);
  assign lane_mask  = 3'(n_q - 4'd1);
  assign mask8      = 8'((9'd1 << n_q) - 9'd1);
  assign sel8       = mask8 << lane;

  assign stb       = (state == ISSUE);
  assign accept    = stb && !wbmstall_i;
  assign ack_en    = (state == ISSUE || state == WAIT) && wbmack_i && (ack_cnt < beats);
  assign acks_done = (ack_cnt + (ack_en ? 3'd1 : 3'd0)) == beats;

  always_comb begin
    state_n = state;
    busy_o  = 1'b0;
    case (state)
      IDLE: begin
        busy_o = mem_i;
        if (mem_i) state_n = misaligned ? RESP : ISSUE;
      end
      ISSUE: begin
        busy_o = 1'b1;
        if (accept && issue_cnt == beats - 3'd1) state_n = acks_done ? RESP : WAIT;
      end
      WAIT: begin
        busy_o = 1'b1;
        if (acks_done) state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // Single-beat loads are lane-aligned down to bit 0; multi-beat loads stack beats by ack order.
  always_comb begin
    result_n = result_q;
    if (ack_en && !we_q) begin
      if (beats == 3'd1) begin
        result_n = 64'(wbmdat_i) >> {lane, 3'b000};
      end else begin
        for (int unsigned j = 0; j < MAXB; j++)
          if (ack_cnt == 3'(j)) result_n[j*DW +: DW] = wbmdat_i;
      end
    end
  end

  always_comb begin
    wbmstb_o = stb;
    wbmwe_o  = stb & we_q;
    wbmadr_o = '0;
    wbmdat_o = '0;
    wbmsel_o = '0;
    if (stb) begin
      wbmadr_o = AW'(addr_q + (64'(issue_cnt) << LSH));
      if (n_q >= 4'(L)) begin
        wbmsel_o = '1;
        for (int unsigned j = 0; j < MAXB; j++)
          if (issue_cnt == 3'(j)) wbmdat_o = dat_q[j*DW +: DW];
      end else begin
        wbmsel_o = L'(sel8);
        for (int unsigned i = 0; i < L; i++)
          wbmdat_o[i*8 +: 8] = dat_q[{3'(i) & lane_mask, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      code_q     <= '0;
      rd_q       <= '0;
      issue_cnt  <= '0;
      ack_cnt    <= '0;
      result_q   <= '0;
      rwe_o      <= '0;
      dat_o      <= '0;
      rd_o       <= '0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_n;
      rwe_o      <= '0;
      dat_o      <= '0;
      rd_o       <= '0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_i) begin
            addr_q    <= addr_i;
            dat_q     <= dat_i;
            we_q      <= we_i;
            code_q    <= xrs_rwe_i;
            rd_q      <= xrs_rd_i;
            issue_cnt <= '0;
            ack_cnt   <= '0;
            result_q  <= '0;
            if (misaligned) begin
              misalign_o <= 1'b1;
              rd_o       <= xrs_rd_i;
            end
          end else if (nomem_i) begin
            rwe_o <= xrs_rwe_i;
            dat_o <= addr_i;
            rd_o  <= xrs_rd_i;
          end
        end
        ISSUE, WAIT: begin
          if (accept) issue_cnt <= issue_cnt + 3'd1;
          if (ack_en) ack_cnt <= ack_cnt + 3'd1;
          result_q <= result_n;
          if (state_n == RESP) begin
            rwe_o <= we_q ? 3'd0 : code_q;
            dat_o <= extend(code_q, result_n);
            rd_o  <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_wide.sv
// Scoreboard bench for lsu_wide at DW=16/32/64: stimulus queues expected writebacks
// and bus beats; a negedge monitor pops and compares whenever each DUT presents them.
module tb_lsu_wide;
  typedef struct packed {
    logic        rst;
    logic [63:0] addr, dat;
    logic        we, mem, nomem;
    logic [2:0]  rwe;
    logic [4:0]  rd;
    logic        ack, stall;
    logic [63:0] wbd;
  } in_t;

  typedef struct packed {
    logic [2:0]  rwe;
    logic [63:0] dat;
    logic [4:0]  rd;
    logic        mis;
    logic [31:0] at;
  } wb_t;

  typedef struct packed {
    logic [63:0] adr, dat;
    logic [7:0]  sel;
    logic        we;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  wb_t   wbq[3][$];
  beat_t bq[3][$];
  logic  pbusy[3];

  in_t i16, i32, i64;

  logic busy16, mis16, we16, stb16;  logic [2:0] rwe16; logic [63:0] dat16, adr16; logic [4:0] rd16;
  logic [15:0] wdat16; logic [1:0] sel16;
  logic busy32, mis32, we32, stb32;  logic [2:0] rwe32; logic [63:0] dat32, adr32; logic [4:0] rd32;
  logic [31:0] wdat32; logic [3:0] sel32;
  logic busy64, mis64, we64, stb64;  logic [2:0] rwe64; logic [63:0] dat64, adr64; logic [4:0] rd64;
  logic [63:0] wdat64; logic [7:0] sel64;

  lsu_wide #(.DW(16), .AW(64)) u_dut16 (
    .clk_i(clk), .reset_i(i16.rst), .addr_i(i16.addr), .dat_i(i16.dat), .we_i(i16.we),
    .mem_i(i16.mem), .nomem_i(i16.nomem), .xrs_rwe_i(i16.rwe), .xrs_rd_i(i16.rd),
    .busy_o(busy16), .rwe_o(rwe16), .dat_o(dat16), .rd_o(rd16), .misalign_o(mis16),
    .wbmadr_o(adr16), .wbmdat_o(wdat16), .wbmsel_o(sel16), .wbmwe_o(we16), .wbmstb_o(stb16),
    .wbmack_i(i16.ack), .wbmstall_i(i16.stall), .wbmdat_i(i16.wbd[15:0]));

  lsu_wide #(.DW(32), .AW(64)) u_dut32 (
    .clk_i(clk), .reset_i(i32.rst), .addr_i(i32.addr), .dat_i(i32.dat), .we_i(i32.we),
    .mem_i(i32.mem), .nomem_i(i32.nomem), .xrs_rwe_i(i32.rwe), .xrs_rd_i(i32.rd),
    .busy_o(busy32), .rwe_o(rwe32), .dat_o(dat32), .rd_o(rd32), .misalign_o(mis32),
    .wbmadr_o(adr32), .wbmdat_o(wdat32), .wbmsel_o(sel32), .wbmwe_o(we32), .wbmstb_o(stb32),
    .wbmack_i(i32.ack), .wbmstall_i(i32.stall), .wbmdat_i(i32.wbd[31:0]));

  lsu_wide #(.DW(64), .AW(64)) u_dut64 (
    .clk_i(clk), .reset_i(i64.rst), .addr_i(i64.addr), .dat_i(i64.dat), .we_i(i64.we),
    .mem_i(i64.mem), .nomem_i(i64.nomem), .xrs_rwe_i(i64.rwe), .xrs_rd_i(i64.rd),
    .busy_o(busy64), .rwe_o(rwe64), .dat_o(dat64), .rd_o(rd64), .misalign_o(mis64),
    .wbmadr_o(adr64), .wbmdat_o(wdat64), .wbmsel_o(sel64), .wbmwe_o(we64), .wbmstb_o(stb64),
    .wbmack_i(i64.ack), .wbmstall_i(i64.stall), .wbmdat_i(i64.wbd));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input int pending);
    checks++;
    $display("FAIL %s: got %0d queued entries, expected none", name, pending);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // lat = cycles from the request edge to the writeback cycle
  task automatic exp_wb(input int id, input logic [2:0] rwe, input logic [63:0] dat,
                        input logic [4:0] rd, input logic mis, input int lat);
    wbq[id].push_back('{rwe, dat, rd, mis, 32'(cyc + 1 + lat)});
  endtask

  task automatic exp_beat(input int id, input logic [63:0] adr, input logic [63:0] dat,
                          input logic [7:0] sel, input logic we);
    bq[id].push_back('{adr, dat, sel, we});
  endtask

  task automatic mon(input int id, input logic rst, input logic busy, input logic [2:0] rwe,
                     input logic [63:0] dat, input logic [4:0] rd, input logic mis,
                     input logic stb, input logic stall, input logic [63:0] adr,
                     input logic [63:0] wdat, input logic [7:0] sel, input logic we);
    wb_t   e;
    beat_t b;
    int    dw = 16 << id;
    if (rst) begin
      pbusy[id] = 1'b0;
      return;
    end
    if ((pbusy[id] && !busy) || rwe != 3'd0 || mis) begin
      if (wbq[id].size() == 0) unexpected($sformatf("wb%0d_unexpected", dw), 0);
      else begin
        e = wbq[id].pop_front();
        chk($sformatf("wb%0d_rwe", dw), 64'(rwe), 64'(e.rwe));
        chk($sformatf("wb%0d_dat", dw), dat, e.dat);
        chk($sformatf("wb%0d_rd", dw), 64'(rd), 64'(e.rd));
        chk($sformatf("wb%0d_misalign", dw), 64'(mis), 64'(e.mis));
        chk($sformatf("wb%0d_cycle", dw), 64'(cyc), 64'(e.at));
        chk($sformatf("wb%0d_busy_in_resp", dw), 64'(busy), 64'd0);
      end
    end
    pbusy[id] = busy;
    if (stb) begin
      if (bq[id].size() == 0) unexpected($sformatf("bus%0d_stb_unexpected", dw), 0);
      else begin
        b = bq[id][0];
        chk($sformatf("bus%0d_adr", dw), adr, b.adr);
        chk($sformatf("bus%0d_dat", dw), wdat, b.dat);
        chk($sformatf("bus%0d_sel", dw), 64'(sel), 64'(b.sel));
        chk($sformatf("bus%0d_we", dw), 64'(we), 64'(b.we));
        if (!stall) void'(bq[id].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, i16.rst, busy16, rwe16, dat16, rd16, mis16, stb16, i16.stall, adr16, 64'(wdat16), 8'(sel16), we16);
    mon(1, i32.rst, busy32, rwe32, dat32, rd32, mis32, stb32, i32.stall, adr32, 64'(wdat32), 8'(sel32), we32);
    mon(2, i64.rst, busy64, rwe64, dat64, rd64, mis64, stb64, i64.stall, adr64, wdat64, sel64, we64);
  end

  task automatic chk_zero(input string tag, input logic busy, input logic stb, input logic we,
                          input logic [2:0] rwe, input logic [63:0] dat, input logic [4:0] rd,
                          input logic mis, input logic [63:0] adr, input logic [63:0] wdat,
                          input logic [7:0] sel);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_stb"}, 64'(stb), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_rwe"}, 64'(rwe), 64'd0);
    chk({tag, "_dat"}, dat, 64'd0);
    chk({tag, "_rd"}, 64'(rd), 64'd0);
    chk({tag, "_misalign"}, 64'(mis), 64'd0);
    chk({tag, "_adr"}, adr, 64'd0);
    chk({tag, "_wdat"}, wdat, 64'd0);
    chk({tag, "_sel"}, 64'(sel), 64'd0);
  endtask

  initial begin
    i16 = '0; i32 = '0; i64 = '0;
    i16.rst = 1'b1; i32.rst = 1'b1; i64.rst = 1'b1;
    tick(); tick();
    chk_zero("rst16", busy16, stb16, we16, rwe16, dat16, rd16, mis16, adr16, 64'(wdat16), 8'(sel16));
    chk_zero("rst64", busy64, stb64, we64, rwe64, dat64, rd64, mis64, adr64, wdat64, sel64);
    i16.rst = 1'b0; i32.rst = 1'b0; i64.rst = 1'b0;
    tick();

    // DW=16 LD D64 @0x1000, four beats, same-cycle acks
    i16.mem = 1'b1; i16.addr = 64'h1000; i16.rwe = 3'b100; i16.we = 1'b0; i16.rd = 5'd7; i16.dat = '0;
    exp_wb(0, 3'b100, 64'h4444_3333_2222_1111, 5'd7, 1'b0, 4);
    for (int k = 0; k < 4; k++) exp_beat(0, 64'h1000 + 64'(2 * k), 64'd0, 8'h03, 1'b0);
    tick(); i16.mem = 1'b0; i16.ack = 1'b1; i16.wbd = 64'h1111;
    tick(); i16.wbd = 64'h2222;
    tick(); i16.wbd = 64'h3333;
    tick(); i16.wbd = 64'h4444;
    tick(); i16.ack = 1'b0; i16.wbd = '0;
    tick(); tick();

    // DW=16 LB S8 then U8 @0x2001, upper lane carries 0x80
    i16.mem = 1'b1; i16.addr = 64'h2001; i16.rwe = 3'b001; i16.rd = 5'd8;
    exp_wb(0, 3'b001, 64'hFFFF_FFFF_FFFF_FF80, 5'd8, 1'b0, 1);
    exp_beat(0, 64'h2001, 64'd0, 8'h02, 1'b0);
    tick(); i16.mem = 1'b0; i16.ack = 1'b1; i16.wbd = 64'h80AB;
    tick(); i16.ack = 1'b0;
    tick(); tick();
    i16.mem = 1'b1; i16.rwe = 3'b101;
    exp_wb(0, 3'b101, 64'h80, 5'd8, 1'b0, 1);
    exp_beat(0, 64'h2001, 64'd0, 8'h02, 1'b0);
    tick(); i16.mem = 1'b0; i16.ack = 1'b1; i16.wbd = 64'h80AB;
    tick(); i16.ack = 1'b0; i16.wbd = '0;
    tick(); tick();

    // DW=16 SB @0x2003: byte replicated into both lanes, upper lane selected
    i16.mem = 1'b1; i16.addr = 64'h2003; i16.rwe = 3'b001; i16.we = 1'b1; i16.rd = 5'd4;
    i16.dat = 64'h1234_5678_9ABC_DE5A;
    exp_wb(0, 3'b000, 64'd0, 5'd4, 1'b0, 1);
    exp_beat(0, 64'h2003, 64'h5A5A, 8'h02, 1'b1);
    tick(); i16.mem = 1'b0; i16.we = 1'b0; i16.ack = 1'b1;
    tick(); i16.ack = 1'b0;
    tick(); tick();

    // DW=32 SW @0x3004 with two stall cycles
    i32.mem = 1'b1; i32.addr = 64'h3004; i32.dat = 64'hDEAD_BEEF; i32.rwe = 3'b011; i32.we = 1'b1; i32.rd = 5'd2;
    exp_wb(1, 3'b000, 64'd0, 5'd2, 1'b0, 3);
    exp_beat(1, 64'h3004, 64'hDEAD_BEEF, 8'h0F, 1'b1);
    tick(); i32.mem = 1'b0; i32.we = 1'b0; i32.stall = 1'b1;
    tick();
    tick(); i32.stall = 1'b0; i32.ack = 1'b1;
    tick(); i32.ack = 1'b0;
    tick(); tick();

    // DW=32 LW S32 with nomem_i also high: memory request wins
    i32.mem = 1'b1; i32.nomem = 1'b1; i32.addr = 64'h7004; i32.dat = '0; i32.rwe = 3'b011; i32.rd = 5'd11;
    exp_wb(1, 3'b011, 64'hFFFF_FFFF_8000_0001, 5'd11, 1'b0, 1);
    exp_beat(1, 64'h7004, 64'd0, 8'h0F, 1'b0);
    tick(); i32.mem = 1'b0; i32.nomem = 1'b0; i32.ack = 1'b1; i32.wbd = 64'h8000_0001;
    tick(); i32.ack = 1'b0; i32.wbd = '0;
    tick(); tick();

    // DW=64 LH S16 @0x4003 is misaligned: pulse only, no strobe
    i64.mem = 1'b1; i64.addr = 64'h4003; i64.rwe = 3'b010; i64.rd = 5'd6;
    exp_wb(2, 3'b000, 64'd0, 5'd6, 1'b1, 0);
    tick(); i64.mem = 1'b0;
    tick(); tick();

    // DW=64 LD D64 @0x6000, ack arrives three cycles after acceptance
    i64.mem = 1'b1; i64.addr = 64'h6000; i64.rwe = 3'b100; i64.rd = 5'd9;
    exp_wb(2, 3'b100, 64'h0123_4567_89AB_CDEF, 5'd9, 1'b0, 4);
    exp_beat(2, 64'h6000, 64'd0, 8'hFF, 1'b0);
    tick(); i64.mem = 1'b0;
    tick(); tick();
    tick(); i64.ack = 1'b1; i64.wbd = 64'h0123_4567_89AB_CDEF;
    tick(); i64.ack = 1'b0; i64.wbd = '0;
    tick(); tick();

    // DW=16 LD D64 @0x5000 reset after two beats; later acks must be ignored
    i16.mem = 1'b1; i16.addr = 64'h5000; i16.rwe = 3'b100; i16.rd = 5'd12; i16.dat = '0;
    for (int k = 0; k < 4; k++) exp_beat(0, 64'h5000 + 64'(2 * k), 64'd0, 8'h03, 1'b0);
    tick(); i16.mem = 1'b0; i16.ack = 1'b1; i16.wbd = 64'hAAAA;
    tick(); i16.wbd = 64'hBBBB;
    tick(); i16.rst = 1'b1;
    #1;
    chk_zero("midrst16", busy16, stb16, we16, rwe16, dat16, rd16, mis16, adr16, 64'(wdat16), 8'(sel16));
    bq[0].delete();
    tick(); i16.rst = 1'b0; i16.wbd = 64'hCCCC;
    tick(); i16.wbd = 64'hDDDD;
    tick(); i16.ack = 1'b0; i16.wbd = '0;
    i16.nomem = 1'b1; i16.addr = 64'd5; i16.rwe = 3'b100; i16.rd = 5'd3;
    exp_wb(0, 3'b100, 64'd5, 5'd3, 1'b0, 0);
    tick(); i16.nomem = 1'b0;
    tick(); tick(); tick();

    for (int id = 0; id < 3; id++) begin
      if (wbq[id].size() != 0) unexpected($sformatf("wb%0d_missing", 16 << id), wbq[id].size());
      if (bq[id].size() != 0) unexpected($sformatf("bus%0d_missing", 16 << id), bq[id].size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
